// File: rtl/key_press_sequencer_pkg.sv
// key_press_sequencer_pkg: shared FSM state encoding and keypad/color-bank widths
package key_press_sequencer_pkg;
   localparam int KEY_ADDR_W = 4;
   localparam int COLOR_W = 3;
   localparam int NUM_KEYS = 16;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DEBOUNCE = 3'd1,
      WRITE = 3'd2,
      TONE = 3'd3,
      RELEASE = 3'd4
   } state_t;
endpackage

// File: rtl/key_press_sequencer_cycle_counter.sv
// cycle_counter: up-counter with sync clear, enable and terminal compare
//   clk, rst : clock, sync active-high reset
//   clr, en  : clear to zero (wins over en), count up by one
//   term     : terminal value; done is high while the count equals it
module cycle_counter #(
   parameter int CNT_W = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             done
);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign done = cnt == term;
endmodule

// File: rtl/key_press_sequencer.sv
// key_press_sequencer: debounces keypad presses into single color-bank writes plus a timed tone gate
//   clk, rst            : clock, sync active-high reset (shared with the color bank)
//   key_pos, key_opr    : raw key position and pressed flag from the scanner
//   wr_en/addr/data     : one-cycle color bank write (key color advanced by one, mod 8)
//   tone_addr, tone_en  : frequency-ROM address and PWM gate
//   busy                : high whenever the FSM is not idle
//   HOLD_TONE_EN        : when defined, tone_en stays high past TONE_CYCLES while the key is held
module key_press_sequencer
   import key_press_sequencer_pkg::*;
#(
   parameter int DEB_CYCLES = 500000,
   parameter int TONE_CYCLES = 25000000,
   parameter int CNT_W = 25
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [KEY_ADDR_W-1:0] key_pos,
   input  logic                  key_opr,
   output logic                  wr_en,
   output logic [KEY_ADDR_W-1:0] wr_addr,
   output logic [COLOR_W-1:0]    wr_data,
   output logic [KEY_ADDR_W-1:0] tone_addr,
   output logic                  tone_en,
   output logic                  busy
);
   localparam logic [CNT_W-1:0] DEB_T = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] TONE_T = CNT_W'(TONE_CYCLES - 1);
   state_t state, nxt;
   logic [KEY_ADDR_W-1:0] pos_q, pos_d;
   logic [COLOR_W-1:0] shadow [NUM_KEYS];
   logic [COLOR_W-1:0] next_color;
   logic clr, en, done;
   assign next_color = shadow[pos_q] + 1'b1;
   cycle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .en(en),
      .term(state == TONE ? TONE_T : DEB_T),
      .done(done)
   );
   always_comb begin
      nxt = state;
      pos_d = pos_q;
      clr = 1'b0;
      en = 1'b0;
      case (state)
         IDLE:
            if (key_opr) begin
               pos_d = key_pos;
               clr = 1'b1;
               nxt = DEBOUNCE;
            end
         DEBOUNCE:
            if (!key_opr) nxt = IDLE;
            else if (key_pos != pos_q) begin
               pos_d = key_pos;
               clr = 1'b1;
            end
            else if (done) nxt = WRITE;
            else en = 1'b1;
         WRITE: begin
            clr = 1'b1;
            nxt = TONE;
         end
         TONE:
            if (!done) en = 1'b1;
`ifdef HOLD_TONE_EN
            else if (!key_opr) begin
               clr = 1'b1;
               nxt = RELEASE;
            end
`else
            else begin
               clr = 1'b1;
               nxt = RELEASE;
            end
`endif
         RELEASE:
            if (key_opr) clr = 1'b1;
            else if (done) nxt = IDLE;
            else en = 1'b1;
         default: nxt = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pos_q <= '0;
         wr_en <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         tone_addr <= '0;
         tone_en <= 1'b0;
         busy <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) shadow[i] <= '0;
      end
      else begin
         state <= nxt;
         pos_q <= pos_d;
         wr_en <= nxt == WRITE;
         tone_en <= nxt == TONE;
         busy <= nxt != IDLE;
         if (nxt == WRITE) begin
            wr_addr <= pos_q;
            wr_data <= next_color;
            tone_addr <= pos_q;
            shadow[pos_q] <= next_color;
         end
      end
   end
endmodule

// File: tb/tb_key_press_sequencer.sv
// tb_key_press_sequencer: directed self-checking bench for key_press_sequencer (DEB_CYCLES=4, TONE_CYCLES=8)
module tb_key_press_sequencer;
`ifdef HOLD_TONE_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_opr = 1'b0;
   logic [3:0] key_pos = 4'd0;
   logic wr_en, tone_en, busy;
   logic [3:0] wr_addr, tone_addr;
   logic [2:0] wr_data;
   int n_cmp = 0, n_err = 0;
   int wr_cnt = 0, tone_cnt = 0, w2_cnt = 0;
   logic [3:0] last_addr = 4'd0;
   logic [2:0] last_data = 3'd0;
   always #5 clk = ~clk;
   key_press_sequencer #(.DEB_CYCLES(4), .TONE_CYCLES(8), .CNT_W(25)) dut (
      .clk(clk),
      .rst(rst),
      .key_pos(key_pos),
      .key_opr(key_opr),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .tone_addr(tone_addr),
      .tone_en(tone_en),
      .busy(busy)
   );
   task automatic tick();
      @(negedge clk);
      if (wr_en) begin
         wr_cnt++;
         last_addr = wr_addr;
         last_data = wr_data;
         if (wr_addr == 4'd2) w2_cnt++;
      end
      if (tone_en) tone_cnt++;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask
   task automatic press(input logic [3:0] p, input int hold);
      key_pos = p;
      key_opr = 1'b1;
      repeat (hold) tick();
      key_opr = 1'b0;
      repeat (20) tick();
   endtask
   initial begin
      repeat (3) tick();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_tone_addr", tone_addr, 0);
      chk("rst_tone_en", tone_en, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();
      // clean press of key 5 held 30 cycles
      wr_cnt = 0;
      tone_cnt = 0;
      key_pos = 4'd5;
      key_opr = 1'b1;
      repeat (4) begin
         tick();
         chk("t1_no_early_wr", wr_en, 0);
      end
      tick();
      chk("t1_wr_en", wr_en, 1);
      chk("t1_wr_addr", wr_addr, 5);
      chk("t1_wr_data", wr_data, 1);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_wr_fall", wr_en, 0);
      chk("t1_tone_en", tone_en, 1);
      chk("t1_tone_addr", tone_addr, 5);
      repeat (24) tick();
      key_opr = 1'b0;
      repeat (20) tick();
      chk("t1_wr_count", wr_cnt, 1);
      chk("t1_tone_len", tone_cnt, HOLD ? 25 : 8);
      chk("t1_idle_busy", busy, 0);
      chk("t1_tone_addr_hold", tone_addr, 5);
      // bounce 1,0,1,1,0 then steady on key 5
      wr_cnt = 0;
      key_opr = 1'b1; tick();
      key_opr = 1'b0; tick();
      key_opr = 1'b1; tick();
      tick();
      key_opr = 1'b0; tick();
      key_opr = 1'b1;
      repeat (4) tick();
      chk("t2_no_wr_bounce", wr_cnt, 0);
      tick();
      chk("t2_wr_en", wr_en, 1);
      chk("t2_wr_data", wr_data, 2);
      repeat (15) tick();
      key_opr = 1'b0;
      repeat (20) tick();
      chk("t2_wr_count", wr_cnt, 1);
      // key 3 nine times: colors wrap 7 -> 0
      wr_cnt = 0;
      for (int i = 1; i <= 9; i++) begin
         press(4'd3, 6);
         chk("t3_wr_data", last_data, i % 8);
         chk("t3_wr_addr", last_addr, 3);
      end
      chk("t3_wr_count", wr_cnt, 9);
      // key 2 changes to 7 mid-debounce
      wr_cnt = 0;
      w2_cnt = 0;
      key_pos = 4'd2;
      key_opr = 1'b1;
      repeat (2) tick();
      key_pos = 4'd7;
      repeat (4) begin
         tick();
         chk("t4_restart_no_wr", wr_en, 0);
      end
      tick();
      chk("t4_wr_en", wr_en, 1);
      chk("t4_wr_addr", wr_addr, 7);
      chk("t4_wr_data", wr_data, 1);
      repeat (20) tick();
      key_opr = 1'b0;
      repeat (20) tick();
      chk("t4_wr_count", wr_cnt, 1);
      chk("t4_addr2_writes", w2_cnt, 0);
      // reset during TONE
      key_pos = 4'd5;
      key_opr = 1'b1;
      repeat (7) tick();
      chk("t5_in_tone", tone_en, 1);
      rst = 1'b1;
      tick();
      chk("t5_rst_tone_en", tone_en, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_wr_en", wr_en, 0);
      chk("t5_rst_tone_addr", tone_addr, 0);
      rst = 1'b0;
      key_opr = 1'b0;
      repeat (3) tick();
      wr_cnt = 0;
      press(4'd5, 6);
      chk("t5_wr_count", wr_cnt, 1);
      chk("t5_wr_data", last_data, 1);
      // key held 40 cycles
      wr_cnt = 0;
      tone_cnt = 0;
      press(4'd6, 40);
      chk("t6_wr_count", wr_cnt, 1);
      chk("t6_wr_data", last_data, 1);
      chk("t6_tone_len", tone_cnt, HOLD ? 35 : 8);
      chk("t6_idle_busy", busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
